image_rate_encoder: RTL
=======================

# image_rate_encoder

Converts the 256-pixel image held in the AXI write-side image buffer into a stream of spike events for the SNN core, using integrate-and-overflow rate coding over `N_STEPS` timesteps. On `start` it scans all pixels once per timestep, reading each pixel through the buffer's synchronous read port. It adds the pixel to a per-pixel 8-bit accumulator and emits that pixel's address as a spike when the add overflows. It sits directly downstream of the AXI4-Lite input interface and upstream of the neuron core's event input.

## Interface
- `NPIX`, 256: pixels per image; fixed at 256, matching the 8-bit address.
- `PW`, 8: pixel and accumulator width in bits.
- `N_STEPS`, 16: timesteps per inference; legal range 1..255.

- `ACLK`  in  1  clock; all logic on its rising edge
- `ARESET`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  one-cycle request to encode the current image; honoured only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse when the last timestep completes
- `pix_raddr`  out  8  image buffer read address
- `pix_rdata`  in  8  image buffer read data; valid one cycle after `pix_raddr`
- `spike_valid`  out  1  spike event valid
- `spike_ready`  in  1  consumer accepts the event
- `spike_addr`  out  8  pixel/input-neuron index of the spike
- `spike_step`  out  8  timestep index of the spike (0..N_STEPS-1)
- `step_done`  out  1  one-cycle pulse after every pixel of a timestep is processed and all its spikes are accepted

## Operation
- Storage: `acc[0:255]`, 8 bits each. Registers: `idx` (8b), `step` (8b), `state`.
- States: IDLE, READ, PROC, EMIT, STEP_END, DONE.
- IDLE: when `start` is high, clear `idx` and `step`, then go to READ. `start` is ignored in every other state.
- READ: drive `pix_raddr = idx`, then go to PROC.
- PROC: compute `sum = {1'b0, acc_old} + pix_rdata` (9 bits).
  - `acc_old` is treated as 0 when `step == 0`. No clear pass is needed.
  - Write `acc[idx] <= sum[7:0]`.
  - If `sum[8]` is set, latch `spike_addr = idx` and `spike_step = step`, then go to EMIT.
  - Otherwise, advance.
- EMIT: hold `spike_valid`, `spike_addr` and `spike_step` stable until `spike_valid && spike_ready`, then advance.
- Advance:
  - If `idx == 255`, go to STEP_END.
  - Otherwise, set `idx <= idx + 1` and go to READ.
- STEP_END: assert `step_done` for one cycle.
  - If `step == N_STEPS-1`, go to DONE.
  - Otherwise, set `step <= step + 1` and `idx <= 0`, then go to READ.
- DONE: assert `done` for one cycle, then go to IDLE.
- Result: pixel value p produces exactly floor(p·N_STEPS/256) spikes per inference. Spikes are ordered by step, then by ascending address.
- Usage rule: the image buffer must not be written while `busy` is high. Behaviour under violation is undefined but must not deadlock.

## Timing
- Reset values:
  - `busy`, `done`, `step_done`, `spike_valid`: 0.
  - `pix_raddr`, `spike_addr`, `spike_step`: 0.
  - State: IDLE.
  - Accumulator contents are don't-care.
- `start` sampled at edge t puts the FSM in READ at t+1, with `busy` = 1 from t+1.
- Pixel without a spike: 2 cycles (READ, PROC).
- Pixel with a spike: 3 cycles minimum (READ, PROC, EMIT with `spike_ready` = 1). Each stall cycle adds one.
- Timestep with zero spikes and no stall: 513 cycles. An inference of all-zero pixels takes N_STEPS·513 + 1 cycles from READ entry to the DONE cycle.
- `spike_valid` rises the cycle after PROC detects a carry. It never drops without acceptance, except on reset.
- `step_done` and `done` are never high in the same cycle. `done` follows the last `step_done` by exactly one cycle.
- Reset mid-operation: the FSM returns to IDLE in the next cycle and all outputs take their reset values, including dropping a pending `spike_valid`. A new `start` re-runs from step 0.
- `start` asserted in the same cycle as DONE is ignored. It is accepted only from IDLE.

## Test plan
- All pixels 0, N_STEPS=16, `spike_ready` = 1:
  - no `spike_valid` ever;
  - 16 `step_done` pulses spaced 513 cycles apart;
  - `done` 8209 cycles after READ entry.
- Pixel 5 = 255, pixel 200 = 128, others 0, N_STEPS=16:
  - addr 5 spikes 15 times (steps 1..15);
  - addr 200 spikes 8 times (odd steps);
  - within each step, addr 5 precedes addr 200.
- Pixel 0 = 16, others 0, N_STEPS=16: exactly one spike, addr 0, `spike_step` = 15.
- Pixel 10 = 255, `spike_ready` held low 20 cycles at the first spike: `spike_valid`, `spike_addr` = 10 and `spike_step` = 1 stay stable throughout; the scan resumes one cycle after acceptance.
- `ARESET` pulsed mid-step 3 while EMIT is stalled:
  - next cycle: all outputs 0, `busy` = 0;
  - a fresh `start` reproduces the full expected spike sequence from step 0.
- `start` pulsed while busy and in the DONE cycle: ignored; exactly one `done` per accepted `start`.

Source files
------------

// File: rtl/image_rate_encoder.sv
// Rate encoder: integrates each pixel into an 8-bit accumulator once per timestep
// and emits the pixel address as a spike whenever the accumulation wraps.
module image_rate_encoder #(
  parameter int NPIX    = 256,
  parameter int PW      = 8,
  parameter int N_STEPS = 16
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    pix_raddr,
  input  logic [PW-1:0] pix_rdata,
  output logic          spike_valid,
  input  logic          spike_ready,
  output logic [7:0]    spike_addr,
  output logic [7:0]    spike_step,
  output logic          step_done
);

  localparam logic [7:0] LAST_IDX  = 8'(NPIX - 1);
  localparam logic [7:0] LAST_STEP = 8'(N_STEPS - 1);

  typedef enum logic [2:0] {IDLE, READ, PROC, EMIT, STEP_END, DONE} state_t;

  state_t        state_reg;
  logic [7:0]    idx_reg;
  logic [7:0]    step_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          step_done_reg;
  logic          spike_valid_reg;
  logic [7:0]    spike_addr_reg;
  logic [7:0]    spike_step_reg;

  logic [PW-1:0] acc_mem [0:NPIX-1];
  logic [PW-1:0] acc_rd_reg;
  logic [PW-1:0] acc_old;
  logic [PW:0]   sum;

  // Accumulator RAM: read in READ so the old value lines up with pix_rdata in PROC.
  always_ff @(posedge ACLK) begin
    if (state_reg == PROC) begin
      acc_mem[idx_reg] <= sum[PW-1:0];
    end
    acc_rd_reg <= acc_mem[idx_reg];
  end

  // Step 0 ignores stale RAM contents, which removes the need for a clear pass.
  assign acc_old = (step_reg == 8'd0) ? '0 : acc_rd_reg;
  assign sum     = {1'b0, acc_old} + {1'b0, pix_rdata};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      step_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      step_done_reg   <= 1'b0;
      spike_valid_reg <= 1'b0;
      spike_addr_reg  <= '0;
      spike_step_reg  <= '0;
    end else begin
      done_reg      <= 1'b0;
      step_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg   <= '0;
            step_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          state_reg <= PROC;
        end
        PROC: begin
          if (sum[PW]) begin
            spike_valid_reg <= 1'b1;
            spike_addr_reg  <= idx_reg;
            spike_step_reg  <= step_reg;
            state_reg       <= EMIT;
          end else if (idx_reg == LAST_IDX) begin
            step_done_reg <= 1'b1;
            state_reg     <= STEP_END;
          end else begin
            idx_reg   <= idx_reg + 8'd1;
            state_reg <= READ;
          end
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid_reg <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              step_done_reg <= 1'b1;
              state_reg     <= STEP_END;
            end else begin
              idx_reg   <= idx_reg + 8'd1;
              state_reg <= READ;
            end
          end
        end
        STEP_END: begin
          if (step_reg == LAST_STEP) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            step_reg  <= step_reg + 8'd1;
            idx_reg   <= '0;
            state_reg <= READ;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign step_done   = step_done_reg;
  assign spike_valid = spike_valid_reg;
  assign spike_addr  = spike_addr_reg;
  assign spike_step  = spike_step_reg;
  assign pix_raddr   = idx_reg;

endmodule
